// File: rtl/dac_frame_sequencer.sv
// -----------------------------------------------------------------------------
// dac_frame_sequencer
//   Buffers 8-bit telemetry words in a small FIFO and replays them to one
//   8-bit DAC channel, one word per word-rate strobe. Also generates the
//   frame-base marker aligned to word 0 of every frame.
//
//   Optional feature macro: DAC_TESTPATTERN_EN
//     When defined, adds i_test_en. While it is high in RUN, the DAC is
//     driven with the low 8 bits of the word counter (a ramp) instead of
//     FIFO data. The FIFO is still popped and underruns are still counted.
//
// Ports
//   i_clk            system clock
//   i_rst_n          asynchronous active-low reset
//   i_word_stb       1-cycle word-rate enable
//   i_wr_en          write strobe, one word per cycle
//   i_wr_data[7:0]   word to enqueue
//   i_test_en        ramp test pattern select (DAC_TESTPATTERN_EN only)
//   o_wr_full        FIFO full; writes while full are dropped
//   o_fill           FIFO occupancy, 0..2**FIFO_AW
//   o_dac_data[7:0]  registered DAC data bus
//   o_dac_clk        DAC latch clock
//   o_frame_mark     frame-base marker
//   o_overflow       sticky dropped-write flag
//   o_underrun_cnt   saturating count of IDLE_CODE substitutions
// -----------------------------------------------------------------------------
module dac_frame_sequencer #(
  parameter int         FIFO_AW     = 4,
  parameter int         FRAME_WORDS = 64,
  parameter int         MARK_WORDS  = 1,
  parameter logic [7:0] IDLE_CODE   = 8'h80,
  parameter int         CLK_DLY     = 2,
  parameter int         CLK_HI      = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_word_stb,
  input  logic               i_wr_en,
  input  logic [7:0]         i_wr_data,
`ifdef DAC_TESTPATTERN_EN
  input  logic               i_test_en,
`endif
  output logic               o_wr_full,
  output logic [FIFO_AW:0]   o_fill,
  output logic [7:0]         o_dac_data,
  output logic               o_dac_clk,
  output logic               o_frame_mark,
  output logic               o_overflow,
  output logic [7:0]         o_underrun_cnt
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int WC_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int PH_W  = $clog2(CLK_DLY + CLK_HI + 1);

  localparam logic [FIFO_AW:0] FILL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] FILL_HALF = (FIFO_AW + 1)'(DEPTH / 2);
  localparam logic [WC_W-1:0]  WC_LAST   = WC_W'(FRAME_WORDS - 1);
  localparam logic [PH_W-1:0]  PH_DLY    = PH_W'(CLK_DLY);
  localparam logic [PH_W-1:0]  PH_END    = PH_W'(CLK_DLY + CLK_HI);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef DAC_TESTPATTERN_EN
  function automatic logic [7:0] ramp_code(input logic [WC_W-1:0] c);
    logic [31:0] t;
    t = 32'(c);
    return t[7:0];
  endfunction
`endif

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_mem [DEPTH];
  logic [FIFO_AW-1:0]  r_wptr, r_rptr;
  logic [FIFO_AW:0]    r_fill;
  logic                r_overflow;
  logic [7:0]          r_underrun;
  logic [WC_W-1:0]     r_word_cnt;
  logic [7:0]          r_dac_data;
  logic                r_frame_mark;
  logic                r_dac_clk;
  logic                r_pulse_act;
  logic [PH_W-1:0]     r_phase;

  logic                w_empty, w_full, w_proc, w_pop, w_push;
  logic [WC_W-1:0]     w_cnt_cur, w_cnt_nxt;
  logic [7:0]          w_word;
  logic [PH_W-1:0]     w_phase_nxt;

  assign w_empty = (r_fill == '0);
  assign w_full  = (r_fill == FILL_FULL);
  // Any strobe outside IDLE emits a word: SYNC handles word 0 on its strobe.
  assign w_proc  = i_word_stb && (r_state != S_IDLE);
  assign w_pop   = w_proc && !w_empty;
  // A write while full is dropped even if a pop frees a slot this cycle.
  assign w_push  = i_wr_en && !w_full;

  // SYNC forces the frame to start at word 0.
  assign w_cnt_cur = (r_state == S_SYNC) ? '0 : r_word_cnt;
  assign w_cnt_nxt = (w_cnt_cur == WC_LAST) ? '0 : w_cnt_cur + 1'b1;

  always_comb begin
    w_word = w_empty ? IDLE_CODE : r_mem[r_rptr];
`ifdef DAC_TESTPATTERN_EN
    if (i_test_en) w_word = ramp_code(w_cnt_cur);
`endif
  end

  assign w_phase_nxt = r_phase + 1'b1;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_fill >= FILL_HALF) w_state_nxt = S_SYNC;
      S_SYNC:  if (i_word_stb)          w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage: contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wr_data;
  end

  // FIFO pointers, occupancy and overflow flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fill     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
      if (i_wr_en && w_full) r_overflow <= 1'b1;
    end
  end

  // Word output stage: data, marker, counters update on the processed strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dac_data   <= IDLE_CODE;
      r_frame_mark <= 1'b0;
      r_word_cnt   <= '0;
      r_underrun   <= 8'd0;
    end else if (w_proc) begin
      r_dac_data   <= w_word;
      r_frame_mark <= (int'(w_cnt_cur) < MARK_WORDS);
      r_word_cnt   <= w_cnt_nxt;
      if (w_empty) r_underrun <= sat_inc8(r_underrun);
    end
  end

  // DAC clock pulse: r_phase counts cycles since the data update; a new
  // strobe restarts the pulse and drops the clock on the update edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dac_clk   <= 1'b0;
      r_pulse_act <= 1'b0;
      r_phase     <= '0;
    end else if (w_proc) begin
      r_dac_clk   <= 1'b0;
      r_pulse_act <= 1'b1;
      r_phase     <= '0;
    end else if (r_pulse_act) begin
      r_phase     <= w_phase_nxt;
      r_dac_clk   <= (w_phase_nxt >= PH_DLY) && (w_phase_nxt < PH_END);
      r_pulse_act <= (w_phase_nxt < PH_END);
    end
  end

  assign o_wr_full      = w_full;
  assign o_fill         = r_fill;
  assign o_dac_data     = r_dac_data;
  assign o_dac_clk      = r_dac_clk;
  assign o_frame_mark   = r_frame_mark;
  assign o_overflow     = r_overflow;
  assign o_underrun_cnt = r_underrun;

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dac_frame_sequencer
//   Scoreboard bench: the stimulus process keeps a queue-based model of the
//   sequencer and pushes the expected word/marker for every processed strobe;
//   a monitor pops an entry on each DAC clock rising edge and compares it.
// -----------------------------------------------------------------------------
module tb_dac_frame_sequencer;

  localparam int         FIFO_AW     = 4;
  localparam int         DEPTH       = 16;
  localparam int         FRAME_WORDS = 64;
  localparam int         MARK_WORDS  = 1;
  localparam logic [7:0] IDLE_CODE   = 8'h80;
  localparam int         CLK_DLY     = 2;
  localparam int         CLK_HI      = 4;
  localparam int         PERIOD      = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             word_stb = 1'b0;
  logic             wr_en = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             wr_full;
  logic [FIFO_AW:0] fill;
  logic [7:0]       dac_data;
  logic             dac_clk;
  logic             frame_mark;
  logic             overflow;
  logic [7:0]       underrun_cnt;

  dac_frame_sequencer #(
    .FIFO_AW(FIFO_AW), .FRAME_WORDS(FRAME_WORDS), .MARK_WORDS(MARK_WORDS),
    .IDLE_CODE(IDLE_CODE), .CLK_DLY(CLK_DLY), .CLK_HI(CLK_HI)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_word_stb(word_stb),
    .i_wr_en(wr_en),
    .i_wr_data(wr_data),
`ifdef DAC_TESTPATTERN_EN
    .i_test_en(1'b0),
`endif
    .o_wr_full(wr_full),
    .o_fill(fill),
    .o_dac_data(dac_data),
    .o_dac_clk(dac_clk),
    .o_frame_mark(frame_mark),
    .o_overflow(overflow),
    .o_underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] data;
    logic       mark;
    int         upd;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: FIFO as a queue, mode 0=waiting 1=armed 2=running
  logic [7:0] m_q[$];
  int         m_mode  = 0;
  int         m_words = 0;
  int         m_under = 0;
  int         m_ovf   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_mode  = 0;
    m_words = 0;
    m_under = 0;
    m_ovf   = 0;
  endtask

  // Drive one clock cycle and advance the model by the same cycle.
  task automatic step(input bit s, input bit w, input logic [7:0] d);
    int   pre;
    exp_t e;
    word_stb = s;
    wr_en    = w;
    wr_data  = d;
    pre = m_q.size();
    if (s && m_mode != 0) begin
      e.upd  = cyc + 1;
      e.mark = ((m_words % FRAME_WORDS) < MARK_WORDS);
      if (pre > 0) e.data = m_q.pop_front();
      else begin
        e.data = IDLE_CODE;
        if (m_under < 255) m_under++;
      end
      m_words++;
      m_mode = 2;
      exp_q.push_back(e);
    end
    if (w) begin
      if (pre < DEPTH) m_q.push_back(d);
      else m_ovf = 1;
    end
    if (m_mode == 0 && pre >= DEPTH / 2) m_mode = 1;
    @(posedge clk);
    #1;
  endtask

  // One word period: strobe on the first cycle, random writes with
  // probability 1/wr_odds (0 disables writes) on every cycle.
  task automatic word_period(input int wr_odds);
    bit w;
    for (int k = 0; k < PERIOD; k++) begin
      w = (wr_odds > 0) && ($urandom_range(0, wr_odds - 1) == 0);
      step(k == 0, w, 8'($urandom));
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_fill"},     fill,         m_q.size());
    check({tag, "_wr_full"},  wr_full,      (m_q.size() == DEPTH));
    check({tag, "_overflow"}, overflow,     m_ovf);
    check({tag, "_underrun"}, underrun_cnt, m_under);
  endtask

  // Monitor: one expected entry per DAC clock rising edge.
  initial begin : monitor
    logic prev;
    int   hi;
    exp_t e;
    prev = 1'b0;
    hi   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
        hi   = 0;
      end else begin
        if (dac_clk && !prev) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_dac_clk: rising edge at cycle %0d with no word expected", cyc);
          end else begin
            e = exp_q.pop_front();
            check("dac_data",   dac_data,   e.data);
            check("frame_mark", frame_mark, e.mark);
            check("clk_dly",    cyc - e.upd, CLK_DLY);
          end
          hi = 1;
        end else if (dac_clk) begin
          hi++;
        end else if (prev) begin
          check("clk_hi", hi, CLK_HI);
        end
        prev = dac_clk;
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_dac_data", dac_data,     IDLE_CODE);
    check("rst_dac_clk",  dac_clk,      0);
    check("rst_mark",     frame_mark,   0);
    check_status("rst");
    rst_n = 1'b1;
    step(0, 0, 8'h00);

    // No data: strobes must leave the output idle.
    for (int i = 0; i < 100; i++) word_period(0);
    check("idle_dac_data", dac_data,   IDLE_CODE);
    check("idle_mark",     frame_mark, 0);
    check("idle_dac_clk",  dac_clk,    0);
    check_status("idle");

    // Eight known words, then drain past empty.
    for (int i = 1; i <= 8; i++) step(0, 1, 8'(i));
    step(0, 0, 8'h00);
    for (int i = 0; i < 12; i++) word_period(0);
    check_status("drain");

    // Burst of 20 writes with no strobes.
    for (int i = 0; i < 20; i++) step(0, 1, 8'($urandom));
    check_status("burst");

    // Long random run across frame boundaries; first strobe pops while full.
    for (int i = 0; i < 140; i++) word_period(7);
    check_status("run");

    // Starve the FIFO long enough to saturate the underrun counter.
    for (int i = 0; i < 270; i++) word_period(0);
    check_status("sat");

    // Reset mid-pulse with 9 words buffered.
    rst_n = 1'b0;
    #1;
    model_reset();
    step(0, 0, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(0, 1, 8'($urandom));
    step(0, 0, 8'h00);
    step(1, 0, 8'h00);
    repeat (3) step(0, 0, 8'h00);
    check("pre_rst_dac_clk", dac_clk, 1);
    check_status("pre_rst");
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_dac_clk",  dac_clk,    0);
    check("mid_rst_dac_data", dac_data,   IDLE_CODE);
    check("mid_rst_mark",     frame_mark, 0);
    check_status("mid_rst");
    step(0, 0, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) word_period(0);
    check("post_rst_dac_data", dac_data, IDLE_CODE);
    check_status("post_rst");

    repeat (PERIOD) step(0, 0, 8'h00);
    check("pending_words", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
